// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage of the pipelined MIPS core.
//
// Holds the PC, fetches instructions over a req/ack handshake and loads the IF/ID
// pipeline register read by decode. Stall/flush come from the hazard unit, redirects
// from the EX/branch logic.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          synchronous active-low reset (0 = reset)
//   stall_i        hold IF/ID and PC
//   flush_i        invalidate IF/ID contents (insert a bubble)
//   redirect_i     taken branch/jump, fetch resumes at redirect_pc_i
//   redirect_pc_i  redirect target, bits [1:0] ignored
//   imem_req_o     fetch request, held until acknowledged
//   imem_addr_o    fetch address (current PC)
//   imem_rdata_i   instruction word, valid on an edge with req && ack
//   imem_ack_i     memory completes the transfer (same-cycle ack allowed)
//   ifid_valid_o   IF/ID holds a real instruction
//   ifid_instr_o   IF/ID instruction
//   ifid_pc_o      PC of the IF/ID instruction
//   ifid_pc4_o     ifid_pc_o + 4
module mips_fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ack_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o
);

    // StDrain: a redirect arrived while a fetch was outstanding; the request cannot be
    // withdrawn, so wait for it, discard the word, then jump to the pending target.
    // StHold: a word arrived during a stall and is parked in the hold buffer.
    typedef enum logic [1:0] {
        StFetch,
        StDrain,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;

    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;

    logic        transfer;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign target   = {redirect_pc_i[31:2], 2'b00};
    assign pc_plus4 = pc_q + 32'd4;

    // The request is tied to the state register only, so it stays stable until acked.
    assign imem_req_o  = reset && (state_q == StFetch || state_q == StDrain);
    assign imem_addr_o = pc_q;
    assign transfer    = imem_req_o && imem_ack_i;

    // Fetch sequencing
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redir_pc_d    = redir_pc_q;
        hold_instr_d  = hold_instr_q;
        deliver       = 1'b0;
        deliver_instr = imem_rdata_i;

        case (state_q)
            StFetch: begin
                if (transfer) begin
                    if (redirect_i) begin
                        pc_d = target;
                    end else if (stall_i) begin
                        hold_instr_d = imem_rdata_i;
                        state_d      = StHold;
                    end else begin
                        deliver = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end else if (redirect_i) begin
                    redir_pc_d = target;
                    state_d    = StDrain;
                end
            end
            StDrain: begin
                if (redirect_i) begin
                    redir_pc_d = target;
                end
                if (transfer) begin
                    pc_d    = redirect_i ? target : redir_pc_q;
                    state_d = StFetch;
                end
            end
            StHold: begin
                if (redirect_i) begin
                    pc_d    = target;
                    state_d = StFetch;
                end else if (!stall_i) begin
                    deliver       = 1'b1;
                    deliver_instr = hold_instr_q;
                    pc_d          = pc_plus4;
                    state_d       = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // IF/ID register: flush beats stall beats delivery; otherwise a bubble.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;

        if (flush_i) begin
            ifid_valid_d = 1'b0;
        end else if (stall_i) begin
            ifid_valid_d = ifid_valid_q;
        end else if (deliver) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = deliver_instr;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
        end else begin
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StFetch;
            pc_q         <= PC_RESET;
            redir_pc_q   <= 32'd0;
            hold_instr_q <= 32'd0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= 32'd0;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            hold_instr_q <= hold_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    assign ifid_valid_o = ifid_valid_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_pc4_o   = ifid_pc4_q;

endmodule
